// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM states, decode constants and FIFO entry layout for the PS/2 receiver
package ps2_pkg;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
   localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
   localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
   typedef struct packed {
      logic       extended;
      logic       brk;
      logic [7:0] code;
   } ps2_entry_t;
endpackage

// File: rtl/ps2_if.sv
// ps2_if: key FIFO consumer handshake between the receiver (master) and its consumer (slave)
interface ps2_if #(parameter int FIFO_DEPTH = 8);
   logic                        key_valid;
   logic                        key_ready;
   logic [7:0]                  key_code;
   logic                        key_break;
   logic                        key_extended;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   modport master (output key_valid, key_code, key_break, key_extended, fifo_count, input key_ready);
   modport slave  (input key_valid, key_code, key_break, key_extended, fifo_count, output key_ready);
endinterface

// File: rtl/ps2_fifo.sv
// ps2_fifo: synchronous first-word-fall-through FIFO with occupancy count
module ps2_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic                     o_valid,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wp, r_rp;
   logic [CW-1:0]    r_cnt;
   logic             w_push, w_pop;
   assign w_pop   = i_pop & (r_cnt != '0);
   assign o_full  = r_cnt == CW'(DEPTH);
   assign w_push  = i_push & (~o_full | w_pop);
   assign o_valid = r_cnt != '0;
   assign o_data  = r_mem[r_rp];
   assign o_count = r_cnt;
   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop) r_rp <= r_rp + AW'(1);
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   // storage needs no reset; the head is gated by o_valid downstream
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wp] <= i_data;
endmodule

// File: rtl/ps2_receiver.sv
// ps2_receiver: PS/2 keyboard frame receiver with glitch filter, timeout and key FIFO; KB_EXTENDED_DECODE_EN enables E0/F0 prefix decoding
module ps2_receiver
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic  VGA_clk,
   input  logic  reset,
   input  logic  kb_clk,
   input  logic  kb_data,
   ps2_if.master key,
   output logic  overflow,
   output logic  frame_err
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [1:0]                  r_clk_s, r_dat_s;
   logic [FILTER_LEN-1:0]       r_filt;
   logic                        r_fclk;
   logic                        w_sample, w_tmo, w_ok;
   ps2_state_t                  r_state, w_state_n;
   logic [2:0]                  r_bit;
   logic [7:0]                  r_shift, r_byte;
   logic                        r_par;
   logic [TW-1:0]               r_tmo;
   logic                        r_bvalid, r_ferr;
   logic                        w_push, w_valid, w_full;
   ps2_entry_t                  w_entry, w_head;
   logic [$clog2(FIFO_DEPTH):0] w_count;
   // synchronize raw PS/2 lines, then debounce the clock by unanimous vote
   always_ff @(posedge VGA_clk or posedge reset)
      if (reset) begin
         r_clk_s <= '1;
         r_dat_s <= '1;
         r_filt  <= '1;
         r_fclk  <= 1'b1;
      end else begin
         r_clk_s <= {r_clk_s[0], kb_clk};
         r_dat_s <= {r_dat_s[0], kb_data};
         r_filt  <= {r_filt[FILTER_LEN-2:0], r_clk_s[1]};
         r_fclk  <= &r_filt ? 1'b1 : ~|r_filt ? 1'b0 : r_fclk;
      end
   assign w_sample = r_fclk & ~|r_filt;
   assign w_tmo    = (r_state != IDLE) && (r_tmo == TW'(TIMEOUT_CYCLES));
   assign w_ok     = (^{r_shift, r_par}) & r_dat_s[1];
   // frame sequencing; a sample always wins over a coincident timeout
   always_comb begin
      w_state_n = r_state;
      if (w_sample)
         case (r_state)
            IDLE:    w_state_n = r_dat_s[1] ? IDLE : DATA;
            DATA:    w_state_n = (r_bit == 3'd7) ? PARITY : DATA;
            PARITY:  w_state_n = STOP;
            default: w_state_n = IDLE;
         endcase
      else if (w_tmo)
         w_state_n = IDLE;
   end
   // state register
   always_ff @(posedge VGA_clk or posedge reset)
      if (reset) r_state <= IDLE;
      else r_state <= w_state_n;
   // bit collection, parity/stop check and inter-bit timeout
   always_ff @(posedge VGA_clk or posedge reset)
      if (reset) begin
         r_tmo    <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_par    <= 1'b0;
         r_byte   <= '0;
         r_bvalid <= 1'b0;
         r_ferr   <= 1'b0;
      end else begin
         r_tmo    <= (w_sample || r_state == IDLE) ? '0 : r_tmo + TW'(1);
         r_bvalid <= 1'b0;
         r_ferr   <= 1'b0;
         if (w_sample) begin
            if (r_state == IDLE) r_bit <= '0;
            if (r_state == DATA) begin
               r_shift <= {r_dat_s[1], r_shift[7:1]};
               r_bit   <= r_bit + 3'd1;
            end
            if (r_state == PARITY) r_par <= r_dat_s[1];
            if (r_state == STOP) begin
               r_bvalid <= w_ok;
               r_ferr   <= ~w_ok;
               r_byte   <= r_shift;
            end
         end else if (w_tmo) r_ferr <= 1'b1;
      end
`ifdef KB_EXTENDED_DECODE_EN
   logic r_ext, r_brk;
   assign w_push  = r_bvalid && r_byte != PS2_EXT_CODE && r_byte != PS2_BREAK_CODE;
   assign w_entry = '{extended: r_ext, brk: r_brk, code: r_byte};
   // prefix bytes arm flags that attach to the next ordinary code
   always_ff @(posedge VGA_clk or posedge reset)
      if (reset) begin
         r_ext <= 1'b0;
         r_brk <= 1'b0;
      end else if (r_bvalid) begin
         r_ext <= (r_byte == PS2_EXT_CODE) ? 1'b1 : (r_byte == PS2_BREAK_CODE) ? r_ext : 1'b0;
         r_brk <= (r_byte == PS2_BREAK_CODE) ? 1'b1 : (r_byte == PS2_EXT_CODE) ? r_brk : 1'b0;
      end
`else
   assign w_push  = r_bvalid;
   assign w_entry = '{extended: 1'b0, brk: 1'b0, code: r_byte};
`endif
   ps2_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(ps2_entry_t))) u_fifo (
      .clk     (VGA_clk),
      .rst     (reset),
      .i_push  (w_push),
      .i_data  (w_entry),
      .i_pop   (key.key_ready),
      .o_valid (w_valid),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_count (w_count)
   );
   assign key.key_valid    = w_valid;
   assign key.key_code     = w_valid ? w_head.code : 8'h00;
   assign key.key_break    = w_valid & w_head.brk;
   assign key.key_extended = w_valid & w_head.extended;
   assign key.fifo_count   = w_count;
   assign overflow         = w_push & w_full & ~(w_valid & key.key_ready);
   assign frame_err        = r_ferr;
endmodule

// File: tb/tb_ps2_receiver.sv
// tb_ps2_receiver: randomized PS/2 frame stimulus checked against a frame-level reference model
module tb_ps2_receiver;
   import ps2_pkg::*;
   localparam int FL = 8;
   localparam int FD = 4;
   localparam int TO = 50000;
   logic clk = 1'b0, rst = 1'b1, kb_clk = 1'b1, kb_data = 1'b1;
   logic overflow, frame_err;
   int   checks = 0, errors = 0, n_ferr = 0, n_ovf = 0, rmode = 0;
   ps2_if #(.FIFO_DEPTH(FD)) kif ();
   ps2_receiver #(.FILTER_LEN(FL), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)) dut (
      .VGA_clk   (clk),
      .reset     (rst),
      .kb_clk    (kb_clk),
      .kb_data   (kb_data),
      .key       (kif),
      .overflow  (overflow),
      .frame_err (frame_err)
   );
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model state: raw input history, bit list of the frame in progress, entry queue
   logic       h [FL+2];
   logic       dh [2];
   logic       m_fclk, m_evt, m_evd, m_pend, m_ferr, m_ext, m_brk;
   logic [7:0] m_byte;
   logic       bits [$];
   ps2_entry_t q [$];
   int         cyc, last;

   function automatic bit pushable(input logic [7:0] b);
`ifdef KB_EXTENDED_DECODE_EN
      return b != 8'hE0 && b != 8'hF0;
`else
      return 1'b1;
`endif
   endfunction

   function automatic bit win_all(input logic v);
      for (int i = 2; i < FL + 2; i++) if (h[i] !== v) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FL + 2; i++) h[i] = 1'b1;
         dh[0] = 1'b1; dh[1] = 1'b1;
         m_fclk = 1'b1; m_evt = 1'b0; m_evd = 1'b1;
         m_pend = 1'b0; m_ferr = 1'b0; m_ext = 1'b0; m_brk = 1'b0; m_byte = '0;
         bits.delete(); q.delete(); cyc = 0; last = 0;
      end else begin
         cyc++;
         if (q.size() > 0 && kif.key_ready) void'(q.pop_front());
         if (m_pend) begin
`ifdef KB_EXTENDED_DECODE_EN
            if (m_byte == 8'hE0) m_ext = 1'b1;
            else if (m_byte == 8'hF0) m_brk = 1'b1;
            else begin
               if (q.size() < FD) q.push_back('{extended: m_ext, brk: m_brk, code: m_byte});
               m_ext = 1'b0; m_brk = 1'b0;
            end
`else
            if (q.size() < FD) q.push_back('{extended: 1'b0, brk: 1'b0, code: m_byte});
`endif
         end
         m_pend = 1'b0; m_ferr = 1'b0;
         if (m_evt) begin
            if (bits.size() != 0 || m_evd == 1'b0) begin
               bits.push_back(m_evd);
               last = cyc;
            end
            if (bits.size() == 11) begin
               logic p;
               p = 1'b0;
               for (int i = 1; i <= 9; i++) p ^= bits[i];
               if (p && bits[10]) begin
                  m_pend = 1'b1;
                  for (int i = 0; i < 8; i++) m_byte[i] = bits[i+1];
               end else m_ferr = 1'b1;
               bits.delete();
            end
         end else if (bits.size() != 0 && cyc == last + TO + 1) begin
            m_ferr = 1'b1;
            bits.delete();
         end
         if (win_all(1'b1)) m_fclk = 1'b1;
         else if (win_all(1'b0)) m_fclk = 1'b0;
         for (int i = FL + 1; i > 0; i--) h[i] = h[i-1];
         h[0] = kb_clk;
         m_evt = m_fclk && win_all(1'b0);
         dh[1] = dh[0]; dh[0] = kb_data;
         m_evd = dh[1];
      end
   end

   // every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (!rst) begin
         ps2_entry_t hd;
         logic ev, eo;
         ev = q.size() > 0;
         hd = '0;
         if (ev) hd = q[0];
         eo = m_pend && pushable(m_byte) && q.size() == FD && !kif.key_ready;
         chk("key_valid", 32'(kif.key_valid), 32'(ev));
         chk("key_code", 32'(kif.key_code), 32'(hd.code));
         chk("key_break", 32'(kif.key_break), 32'(hd.brk));
         chk("key_extended", 32'(kif.key_extended), 32'(hd.extended));
         chk("fifo_count", 32'(kif.fifo_count), 32'(q.size()));
         chk("frame_err", 32'(frame_err), 32'(m_ferr));
         chk("overflow", 32'(overflow), 32'(eo));
      end
      if (frame_err) n_ferr++;
      if (overflow) n_ovf++;
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rmode == 2) kif.key_ready = 1'($urandom_range(0, 1));
      else if (rmode == 3) kif.key_ready = m_pend;
   endtask

   task automatic wait_n(input int n);
      repeat (n) step();
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits, input int gl);
      logic [10:0] f;
      f = {1'b1, ~(^b) ^ bad, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         kb_data = f[i];
         if (i == gl) begin
            wait_n(20); kb_clk = 1'b0; step(); kb_clk = 1'b1; wait_n(10);
         end else wait_n(int'($urandom_range(15, 25)));
         kb_clk = 1'b0;
         wait_n(int'($urandom_range(15, 25)));
         kb_clk = 1'b1;
      end
      wait_n(30);
   endtask

   task automatic drain();
      kif.key_ready = 1'b1;
      wait_n(FD + 2);
      kif.key_ready = 1'b0;
      step();
   endtask

   initial begin
      int f0, o0;
      logic [7:0] codes [5];
      logic [7:0] b;
      kif.key_ready = 1'b0;
      codes[0] = 8'h15; codes[1] = 8'h24; codes[2] = 8'h2D; codes[3] = 8'h3C; codes[4] = 8'h4B;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(kif.key_valid), 0);
      chk("rst_count", 32'(kif.fifo_count), 0);
      chk("rst_code", 32'(kif.key_code), 0);
      chk("rst_ferr", 32'(frame_err), 0);
      chk("rst_ovf", 32'(overflow), 0);
      step();
      rst = 1'b0;
      wait_n(20);
      send_frame(8'h1C, 1'b0, 11, -1);
      chk("good_valid", 32'(kif.key_valid), 1);
      chk("good_code", 32'(kif.key_code), 32'h1C);
      chk("good_brk", 32'(kif.key_break), 0);
      chk("good_ext", 32'(kif.key_extended), 0);
      kif.key_ready = 1'b1; step(); kif.key_ready = 1'b0; step();
      chk("pop_count", 32'(kif.fifo_count), 0);
      f0 = n_ferr;
      send_frame(8'h1C, 1'b1, 11, -1);
      chk("par_ferr", 32'(n_ferr - f0), 1);
      chk("par_count", 32'(kif.fifo_count), 0);
      send_frame(8'h1C, 1'b0, 11, 3);
      chk("glitch_code", 32'(kif.key_code), 32'h1C);
      chk("glitch_count", 32'(kif.fifo_count), 1);
      drain();
      send_frame(8'hF0, 1'b0, 11, -1);
      send_frame(8'h1C, 1'b0, 11, -1);
`ifdef KB_EXTENDED_DECODE_EN
      chk("brk_count", 32'(kif.fifo_count), 1);
      chk("brk_code", 32'(kif.key_code), 32'h1C);
      chk("brk_flag", 32'(kif.key_break), 1);
`else
      chk("raw_count", 32'(kif.fifo_count), 2);
      chk("raw_code", 32'(kif.key_code), 32'hF0);
      chk("raw_brk", 32'(kif.key_break), 0);
`endif
      drain();
      send_frame(8'hE0, 1'b0, 11, -1);
      send_frame(8'hF0, 1'b0, 11, -1);
      send_frame(8'h75, 1'b0, 11, -1);
`ifdef KB_EXTENDED_DECODE_EN
      chk("ext_count", 32'(kif.fifo_count), 1);
      chk("ext_code", 32'(kif.key_code), 32'h75);
      chk("ext_flag", 32'(kif.key_extended), 1);
      chk("ext_brk", 32'(kif.key_break), 1);
`else
      chk("raw3_count", 32'(kif.fifo_count), 3);
      chk("raw3_code", 32'(kif.key_code), 32'hE0);
      chk("raw3_ext", 32'(kif.key_extended), 0);
`endif
      drain();
      f0 = n_ferr;
      send_frame(8'h5A, 1'b0, 5, -1);
      wait_n(TO + 100);
      chk("tmo_ferr", 32'(n_ferr - f0), 1);
      send_frame(8'h29, 1'b0, 11, -1);
      chk("tmo_next_code", 32'(kif.key_code), 32'h29);
      chk("tmo_next_count", 32'(kif.fifo_count), 1);
      drain();
      f0 = n_ferr;
      send_frame(8'h33, 1'b0, 6, -1);
      rst = 1'b1; wait_n(3); rst = 1'b0; wait_n(50);
      chk("rst_mid_ferr", 32'(n_ferr - f0), 0);
      send_frame(8'h44, 1'b0, 11, -1);
      chk("rst_next_code", 32'(kif.key_code), 32'h44);
      drain();
      o0 = n_ovf;
      for (int i = 0; i < 5; i++) send_frame(codes[i], 1'b0, 11, -1);
      chk("full_count", 32'(kif.fifo_count), 4);
      chk("full_ovf", 32'(n_ovf - o0), 1);
      chk("full_head", 32'(kif.key_code), 32'h15);
      rmode = 3;
      send_frame(8'h5B, 1'b0, 11, -1);
      rmode = 0; kif.key_ready = 1'b0; step();
      chk("pp_count", 32'(kif.fifo_count), 4);
      chk("pp_ovf", 32'(n_ovf - o0), 1);
      for (int i = 1; i < 4; i++) begin
         chk("order_code", 32'(kif.key_code), 32'(codes[i]));
         kif.key_ready = 1'b1; step(); kif.key_ready = 1'b0; step();
      end
      chk("order_last", 32'(kif.key_code), 32'h5B);
      drain();
      rmode = 2;
      for (int n = 0; n < 20; n++) begin
         int r;
         r = int'($urandom_range(0, 7));
         b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
         send_frame(b, $urandom_range(0, 7) == 0, 11, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1);
         wait_n(int'($urandom_range(0, 40)));
      end
      rmode = 0;
      drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ps2_receiver.md
PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8, length of the kb_clk glitch-filter shift register (at least 2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, number of buffered key entries (power of 2, at least 2).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000, VGA_clk cycles allowed between PS/2 bits before a frame is aborted (2 ms at 25 MHz).
REQ-004 SHALL have one clock and an asynchronous, active-high reset, listed as the first two ports below.
REQ-005 Ports, one per line: name, direction, width, meaning.
- VGA_clk  in  1  system clock, 25 MHz.
- reset  in  1  asynchronous, active-high reset.
- kb_clk  in  1  raw PS/2 clock, asynchronous to VGA_clk.
- kb_data  in  1  raw PS/2 data, asynchronous to VGA_clk.
- key_valid  out  1  FIFO head entry valid.
- key_ready  in  1  consumer accepts the head entry.
- key_code  out  8  head scan code; 0 when key_valid=0.
- key_break  out  1  head entry is a release (preceded by F0).
- key_extended  out  1  head entry is extended (preceded by E0).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- overflow  out  1  one-cycle pulse when a byte is dropped because the FIFO is full.
- frame_err  out  1  one-cycle pulse on parity, stop-bit or timeout error.

Function
REQ-006 kb_clk and kb_data SHALL each pass through a 2-flop synchronizer before any other use.
REQ-007 Filtered clock SHALL go to 1 when all FILTER_LEN samples of synced kb_clk are 1, go to 0 when all are 0, and otherwise hold its value.
REQ-008 A sample event SHALL be a single-cycle pulse in the cycle the filtered clock changes 1->0; synced kb_data is captured in that same cycle.
REQ-009 FSM states SHALL be IDLE, DATA, PARITY and STOP.
- IDLE->DATA on a sample with data=0; a sample with data=1 is ignored.
- DATA->PARITY after 8 samples, shifted in LSB first.
- PARITY->STOP after 1 sample.
- STOP->IDLE after 1 sample.
REQ-010 A frame SHALL be accepted only if the 8 data bits plus the parity bit have odd parity and the stop bit=1; otherwise frame_err pulses in the cycle after the stop sample and the byte is discarded.
REQ-011 The timeout counter SHALL clear on every sample event; if it reaches TIMEOUT_CYCLES while the FSM is not in IDLE, the FSM returns to IDLE, frame_err pulses once and the partial byte is discarded.
REQ-012 An accepted byte SHALL reach the decode stage in the cycle after the stop sample; any pushed entry SHALL be visible on key_valid 2 cycles after the stop sample.
REQ-013 The FIFO SHALL be first-word-fall-through; an entry is popped when key_valid and key_ready are both 1 in the same cycle.
REQ-014 A push while full with no pop in that cycle SHALL drop the new entry and pulse overflow; a push and a pop in the same cycle when full SHALL both succeed and fifo_count is unchanged.
REQ-015 A pop while empty SHALL have no effect; read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-016 On reset: FSM in IDLE, FIFO empty, fifo_count=0, all outputs 0, filter register all ones, filtered clock=1, timeout counter=0, decode flags cleared.
REQ-017 Reset asserted mid-frame SHALL discard the partial frame without pulsing frame_err.

Configuration
REQ-018 With KB_EXTENDED_DECODE_EN defined:
- accepted byte 8'hE0 sets an extended-pending flag and is not pushed;
- accepted byte 8'hF0 sets a break-pending flag and is not pushed;
- any other accepted byte is pushed with the pending flags as key_extended/key_break, then both flags clear.
REQ-019 Without KB_EXTENDED_DECODE_EN: every accepted byte SHALL be pushed raw, key_break=key_extended=0, and no pending-flag logic is present.

Structure
REQ-020 Package ps2_pkg SHALL hold the FSM state enum, the constants PS2_EXT_CODE=8'hE0 and PS2_BREAK_CODE=8'hF0, and the FIFO entry struct {extended, brk, code[7:0]}.
REQ-021 The FIFO SHALL be the sub-module ps2_fifo (synchronous, parameterised depth and width, FWFT); the filter, FSM and decode logic stay in ps2_receiver.

Verification
REQ-022 Frame 0x1C with correct parity -> key_valid=1, key_code=8'h1C, key_break=0, key_extended=0; pop leaves fifo_count=0.
REQ-023 With macro defined, bytes F0 then 1C -> one entry, key_code=8'h1C, key_break=1; bytes E0, F0, 75 -> one entry with extended=1, break=1, code=8'h75.
REQ-024 Frame 0x1C with a flipped parity bit -> one frame_err pulse, fifo_count stays 0; a 1-cycle glitch on kb_clk causes no sample event.
REQ-025 Stop kb_clk after 4 data bits for more than 50000 cycles -> frame_err pulse, FSM in IDLE; the next valid frame 0x29 is received correctly.
REQ-026 With FIFO_DEPTH=4, key_ready=0, send 5 frames -> fifo_count=4, one overflow pulse, the first 4 codes pop in order; push and pop in the same cycle at full -> fifo_count stays 4.
